pipeline_fwd_src: RTL and testbench
===================================

# pipeline_fwd_src

Producer side of the operand-forwarding path. It registers each instruction's destination address and result as the instruction moves through three points: p3→p4, p4→p5 and p5→p2. These registered pairs drive the forwarding comparators and the register-file write port. It also detects load-use hazards against the instruction being decoded in p2 and asserts a one-cycle stall. Register 0 is the null destination: an empty or bubble slot presents address 0 and data 0.

## Interface
- DATA_WIDTH, 16, operand/result width (from params_proc.v)
- REG_ADDR_WIDTH, 4, register address width (from params_proc.v)
- clk  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ex_wr_en  in  1  instruction leaving p3 writes a register
- ex_is_load  in  1  instruction leaving p3 is a load; ex_data is then the memory address
- ex_addr  in  REG_ADDR_WIDTH  destination register of the p3 instruction
- ex_data  in  DATA_WIDTH  ALU result of the p3 instruction
- mem_rdata  in  DATA_WIDTH  load data, valid in the cycle a load occupies p34
- flush  in  1  kill the instruction leaving p3 (taken branch)
- A_addr, B_addr  in  REG_ADDR_WIDTH  source registers of the instruction in p2
- A_used, B_used  in  1  source operand is actually read
- reg_addr_p34, reg_addr_p45, reg_addr_p52  out  REG_ADDR_WIDTH  registered destination per stage
- reg_data_p34, reg_data_p45, reg_data_p52  out  DATA_WIDTH  registered data per stage
- rf_we  out  1  register-file write enable, equals (reg_addr_p52 != 0)
- stall  out  1  hold PC and p2, inject bubble into p3

## Operation
- p34 capture on every edge:
  - If ex_wr_en && !flush && ex_addr != 0: addr = ex_addr, data = ex_data, load flag = ex_is_load.
  - Otherwise: addr 0, data 0, load flag 0 (bubble).
- p45 capture: addr = reg_addr_p34; data = mem_rdata if the p34 load flag is set, else reg_data_p34.
- p52 capture: copy of p45.
- The registers are never held. stall only affects upstream stages. A bubble reaches p3 through ex_wr_en=0 on the following cycle.
- stall (combinational) = p34 load flag && reg_addr_p34 != 0 && ((A_used && A_addr == reg_addr_p34) || (B_used && B_addr == reg_addr_p34)).
- While stall is high, reg_data_p34 carries the load address. Consumers must discard the operand in that cycle.
- When flush and stall are both high, flush takes precedence for the p34 capture. stall is still reported; upstream discards it because of the flush.
- A source address of 0 never raises stall.

## Timing
- Reset (asynchronous): all addr/data outputs 0, load flag 0, rf_we 0, stall 0. Reset mid-stream discards all in-flight entries immediately, without waiting for a clock edge.
- Latency:
  - ex_* to reg_*_p34: 1 cycle.
  - ex_* to reg_*_p45: 2 cycles.
  - ex_* to reg_*_p52 and rf_we: 3 cycles.
- Load data is sampled from mem_rdata in the single cycle the load sits in p34.
- stall lasts exactly 1 cycle per load-use. The next cycle the load is in p45, its flag is gone and stall deasserts.
- Back-to-back writes to the same register coexist in different stages. Forward priority belongs to the consumer.

## Configuration
- PIPE_PERF_CNT_EN defined adds two outputs:
  - stall_cnt (16-bit): increments on each cycle with stall high.
  - flush_cnt (16-bit): increments on each cycle with flush high.
  - Both saturate at 0xFFFF and reset to 0 on RST.
- PIPE_PERF_CNT_EN undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- ALU chain: ex_wr_en=1, ex_addr=3, ex_data=0x1234 for one cycle. Required: reg_addr_p34=3/0x1234 at +1, p45 at +2, p52 with rf_we=1 at +3, then all 0.
- Load-use: load to r5 with address 0x0040, mem_rdata=0xBEEF in the next cycle, A_addr=5, A_used=1. Required: stall=1 for exactly one cycle, then reg_data_p45=0xBEEF and stall=0.
- Unused operand: same load with A_addr=5, A_used=0. Required: stall stays 0.
- Flush: ex_wr_en=1, ex_addr=7, flush=1. Required: p34 shows addr 0 / data 0 and rf_we never pulses for r7.
- Null register: ex_addr=0 with ex_wr_en=1 and ex_data=0xFFFF. Required: bubble, rf_we=0. A load to r0 with A_addr=0 gives stall=0.
- Reset mid-operation: RST asserted asynchronously with three valid entries in flight. Required: all outputs 0 before the next clock edge. With PIPE_PERF_CNT_EN, 70000 stall cycles leave stall_cnt=0xFFFF.

Source files
------------

// File: rtl/pipeline_fwd_src.sv
// Forwarding source registers (p34/p45/p52) and load-use stall detect.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush counters.
module pipeline_fwd_src #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_data,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] A_addr,
  input  logic [REG_ADDR_WIDTH-1:0] B_addr,
  input  logic                      A_used,
  input  logic                      B_used,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_p34,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_p45,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_p52,
  output logic [DATA_WIDTH-1:0]     reg_data_p34,
  output logic [DATA_WIDTH-1:0]     reg_data_p45,
  output logic [DATA_WIDTH-1:0]     reg_data_p52,
  output logic                      rf_we,
  output logic                      stall
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               flush_cnt
`endif
);

  localparam logic [REG_ADDR_WIDTH-1:0] RZ = '0;
  localparam logic [DATA_WIDTH-1:0]     DZ = '0;

  logic [REG_ADDR_WIDTH-1:0] a34_q, a34_d;
  logic [REG_ADDR_WIDTH-1:0] a45_q, a45_d;
  logic [REG_ADDR_WIDTH-1:0] a52_q, a52_d;
  logic [DATA_WIDTH-1:0]     d34_q, d34_d;
  logic [DATA_WIDTH-1:0]     d45_q, d45_d;
  logic [DATA_WIDTH-1:0]     d52_q, d52_d;
  logic                      ld34_q, ld34_d;
  logic                      p34_vld;
  logic                      a_hit, b_hit;

  // Flush and r0 both turn the slot into a bubble.
  assign p34_vld = ex_wr_en && !flush && (ex_addr != RZ);

  always_comb begin
    a34_d  = RZ;
    d34_d  = DZ;
    ld34_d = 1'b0;
    if (p34_vld) begin
      a34_d  = ex_addr;
      d34_d  = ex_data;
      ld34_d = ex_is_load;
    end
  end

  always_comb begin
    a45_d = a34_q;
    d45_d = ld34_q ? mem_rdata : d34_q;
    a52_d = a45_q;
    d52_d = d45_q;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      a34_q  <= RZ;
      d34_q  <= DZ;
      ld34_q <= 1'b0;
      a45_q  <= RZ;
      d45_q  <= DZ;
      a52_q  <= RZ;
      d52_q  <= DZ;
    end else begin
      a34_q  <= a34_d;
      d34_q  <= d34_d;
      ld34_q <= ld34_d;
      a45_q  <= a45_d;
      d45_q  <= d45_d;
      a52_q  <= a52_d;
      d52_q  <= d52_d;
    end
  end

  assign a_hit = A_used && (A_addr == a34_q);
  assign b_hit = B_used && (B_addr == a34_q);
  assign stall = ld34_q && (a34_q != RZ) && (a_hit || b_hit);

  assign reg_addr_p34 = a34_q;
  assign reg_addr_p45 = a45_q;
  assign reg_addr_p52 = a52_q;
  assign reg_data_p34 = d34_q;
  assign reg_data_p45 = d45_q;
  assign reg_data_p52 = d52_q;
  assign rf_we        = (a52_q != RZ);

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] scnt_q, scnt_d;
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (stall && scnt_q != 16'hFFFF)
      scnt_d = scnt_q + 16'd1;
    if (flush && fcnt_q != 16'hFFFF)
      fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      scnt_q <= 16'd0;
      fcnt_q <= 16'd0;
    end else begin
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign stall_cnt = scnt_q;
  assign flush_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_pipeline_fwd_src.sv
// Directed bench for pipeline_fwd_src.
// Drives on the falling edge, checks on the following falling edge.
module tb_pipeline_fwd_src;

  logic        clk;
  logic        RST;
  logic        ex_wr_en;
  logic        ex_is_load;
  logic [3:0]  ex_addr;
  logic [15:0] ex_data;
  logic [15:0] mem_rdata;
  logic        flush;
  logic [3:0]  A_addr;
  logic [3:0]  B_addr;
  logic        A_used;
  logic        B_used;
  logic [3:0]  reg_addr_p34;
  logic [3:0]  reg_addr_p45;
  logic [3:0]  reg_addr_p52;
  logic [15:0] reg_data_p34;
  logic [15:0] reg_data_p45;
  logic [15:0] reg_data_p52;
  logic        rf_we;
  logic        stall;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipeline_fwd_src #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) dut (
    .clk(clk),
    .RST(RST),
    .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load),
    .ex_addr(ex_addr),
    .ex_data(ex_data),
    .mem_rdata(mem_rdata),
    .flush(flush),
    .A_addr(A_addr),
    .B_addr(B_addr),
    .A_used(A_used),
    .B_used(B_used),
    .reg_addr_p34(reg_addr_p34),
    .reg_addr_p45(reg_addr_p45),
    .reg_addr_p52(reg_addr_p52),
    .reg_data_p34(reg_data_p34),
    .reg_data_p45(reg_data_p45),
    .reg_data_p52(reg_data_p52),
    .rf_we(rf_we),
    .stall(stall)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    ex_wr_en   = 1'b0;
    ex_is_load = 1'b0;
    ex_addr    = 4'd0;
    ex_data    = 16'd0;
    mem_rdata  = 16'd0;
    flush      = 1'b0;
    A_addr     = 4'd0;
    B_addr     = 4'd0;
    A_used     = 1'b0;
    B_used     = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_addr_p34, reg_addr_p45, reg_addr_p52} !== 12'h000) begin
      errors++;
      $display("FAIL reset_addr got=%h want=000",
               {reg_addr_p34, reg_addr_p45, reg_addr_p52});
    end
    checks++;
    if ({reg_data_p34, reg_data_p45, reg_data_p52, rf_we, stall} !== 50'd0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0",
               {reg_data_p34, reg_data_p45, reg_data_p52, rf_we, stall});
    end
    RST = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_chain();
    ex_wr_en = 1'b1;
    ex_addr  = 4'd3;
    ex_data  = 16'h1234;
    @(negedge clk);
    idle();
    checks++;
    if (reg_addr_p34 !== 4'd3 || reg_data_p34 !== 16'h1234) begin
      errors++;
      $display("FAIL alu_p34 got=%h/%h want=3/1234", reg_addr_p34, reg_data_p34);
    end
    @(negedge clk);
    checks++;
    if (reg_addr_p45 !== 4'd3 || reg_data_p45 !== 16'h1234 || reg_addr_p34 !== 4'd0) begin
      errors++;
      $display("FAIL alu_p45 got=%h/%h p34=%h want=3/1234 p34=0",
               reg_addr_p45, reg_data_p45, reg_addr_p34);
    end
    @(negedge clk);
    checks++;
    if (reg_addr_p52 !== 4'd3 || reg_data_p52 !== 16'h1234 || rf_we !== 1'b1) begin
      errors++;
      $display("FAIL alu_p52 got=%h/%h we=%b want=3/1234 we=1",
               reg_addr_p52, reg_data_p52, rf_we);
    end
    @(negedge clk);
    checks++;
    if (reg_addr_p52 !== 4'd0 || reg_data_p52 !== 16'h0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL alu_empty got=%h/%h we=%b want=0/0000 we=0",
               reg_addr_p52, reg_data_p52, rf_we);
    end
  endtask

  task automatic test_load_use();
    ex_wr_en   = 1'b1;
    ex_is_load = 1'b1;
    ex_addr    = 4'd5;
    ex_data    = 16'h0040;
    A_addr     = 4'd5;
    A_used     = 1'b1;
    @(negedge clk);
    ex_wr_en   = 1'b0;
    ex_is_load = 1'b0;
    mem_rdata  = 16'hBEEF;
    checks++;
    if (stall !== 1'b1 || reg_data_p34 !== 16'h0040) begin
      errors++;
      $display("FAIL load_stall got=%b/%h want=1/0040", stall, reg_data_p34);
    end
    @(negedge clk);
    mem_rdata = 16'h0000;
    checks++;
    if (stall !== 1'b0 || reg_addr_p45 !== 4'd5 || reg_data_p45 !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_data got=%b %h/%h want=0 5/beef",
               stall, reg_addr_p45, reg_data_p45);
    end
    drain();
  endtask

  task automatic test_operand_use();
    ex_wr_en   = 1'b1;
    ex_is_load = 1'b1;
    ex_addr    = 4'd5;
    ex_data    = 16'h0040;
    A_addr     = 4'd5;
    A_used     = 1'b0;
    B_addr     = 4'd5;
    B_used     = 1'b0;
    @(negedge clk);
    idle();
    A_addr = 4'd5;
    B_addr = 4'd5;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL unused_op got=%b want=0", stall);
    end
    B_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL b_used got=%b want=1", stall);
    end
    B_addr = 4'd6;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL b_other got=%b want=0", stall);
    end
    drain();
  endtask

  task automatic test_flush();
    ex_wr_en = 1'b1;
    ex_addr  = 4'd7;
    ex_data  = 16'h5A5A;
    flush    = 1'b1;
    @(negedge clk);
    idle();
    checks++;
    if (reg_addr_p34 !== 4'd0 || reg_data_p34 !== 16'h0) begin
      errors++;
      $display("FAIL flush_p34 got=%h/%h want=0/0000", reg_addr_p34, reg_data_p34);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || reg_addr_p52 === 4'd7) begin
        errors++;
        $display("FAIL flush_we%0d got=%b/%h want=0/0", i, rf_we, reg_addr_p52);
      end
    end
  endtask

  task automatic test_flush_stall();
    ex_wr_en   = 1'b1;
    ex_is_load = 1'b1;
    ex_addr    = 4'd9;
    ex_data    = 16'h0100;
    A_addr     = 4'd9;
    A_used     = 1'b1;
    @(negedge clk);
    ex_is_load = 1'b0;
    ex_addr    = 4'd4;
    ex_data    = 16'h4444;
    flush      = 1'b1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL fs_stall got=%b want=1", stall);
    end
    @(negedge clk);
    idle();
    checks++;
    if (reg_addr_p34 !== 4'd0 || reg_addr_p45 !== 4'd9 || stall !== 1'b0) begin
      errors++;
      $display("FAIL fs_flush got=%h/%h st=%b want=0/9 st=0",
               reg_addr_p34, reg_addr_p45, stall);
    end
    drain();
  endtask

  task automatic test_null_reg();
    ex_wr_en = 1'b1;
    ex_addr  = 4'd0;
    ex_data  = 16'hFFFF;
    @(negedge clk);
    idle();
    checks++;
    if (reg_addr_p34 !== 4'd0 || reg_data_p34 !== 16'h0) begin
      errors++;
      $display("FAIL null_p34 got=%h/%h want=0/0000", reg_addr_p34, reg_data_p34);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || reg_data_p52 !== 16'h0) begin
      errors++;
      $display("FAIL null_we got=%b/%h want=0/0000", rf_we, reg_data_p52);
    end
    ex_wr_en   = 1'b1;
    ex_is_load = 1'b1;
    ex_addr    = 4'd0;
    ex_data    = 16'h0080;
    A_addr     = 4'd0;
    A_used     = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL null_stall got=%b want=0", stall);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    ex_wr_en = 1'b1;
    ex_addr  = 4'd2;
    ex_data  = 16'h0011;
    @(negedge clk);
    ex_data = 16'h0022;
    @(negedge clk);
    idle();
    checks++;
    if (reg_addr_p34 !== 4'd2 || reg_data_p34 !== 16'h0022 ||
        reg_addr_p45 !== 4'd2 || reg_data_p45 !== 16'h0011) begin
      errors++;
      $display("FAIL b2b got=%h/%h %h/%h want=2/0022 2/0011",
               reg_addr_p34, reg_data_p34, reg_addr_p45, reg_data_p45);
    end
    @(negedge clk);
    checks++;
    if (reg_data_p52 !== 16'h0011 || reg_data_p45 !== 16'h0022 || rf_we !== 1'b1) begin
      errors++;
      $display("FAIL b2b_p52 got=%h/%h we=%b want=0011/0022 we=1",
               reg_data_p52, reg_data_p45, rf_we);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    ex_wr_en = 1'b1;
    ex_addr  = 4'd1;
    ex_data  = 16'hAAAA;
    @(negedge clk);
    ex_addr = 4'd2;
    ex_data = 16'hBBBB;
    @(negedge clk);
    ex_addr = 4'd3;
    ex_data = 16'hCCCC;
    @(negedge clk);
    idle();
    checks++;
    if (reg_addr_p34 !== 4'd3 || reg_addr_p45 !== 4'd2 || reg_addr_p52 !== 4'd1) begin
      errors++;
      $display("FAIL mid_fill got=%h/%h/%h want=3/2/1",
               reg_addr_p34, reg_addr_p45, reg_addr_p52);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({reg_addr_p34, reg_addr_p45, reg_addr_p52, rf_we, stall} !== 14'd0 ||
        {reg_data_p34, reg_data_p45, reg_data_p52} !== 48'd0) begin
      errors++;
      $display("FAIL mid_reset got=%h %h want=0 0",
               {reg_addr_p34, reg_addr_p45, reg_addr_p52, rf_we, stall},
               {reg_data_p34, reg_data_p45, reg_data_p52});
    end
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    RST = 1'b1;
    idle();
    @(negedge clk);
    RST = 1'b0;
    flush = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    checks++;
    if (flush_cnt !== 16'd3) begin
      errors++;
      $display("FAIL flush_cnt got=%h want=0003", flush_cnt);
    end
    ex_wr_en   = 1'b1;
    ex_is_load = 1'b1;
    ex_addr    = 4'd5;
    A_addr     = 4'd5;
    A_used     = 1'b1;
    repeat (70001) @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_cnt got=%h want=ffff", stall_cnt);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_operand_use();
    test_flush();
    test_flush_stall();
    test_null_reg();
    test_back_to_back();
    test_reset_mid();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
